nic_port_lookup: RTL
====================

Name: nic_port_lookup

Overview:
- Per-packet output-port lookup stage directly upstream of the crypto processing stage in the crypto_switch data path.
- Accepts 256-bit AXI-Stream packets from the input arbiter. Writes the destination-port byte in tuser on the first beat of each packet, then forwards the packet unchanged otherwise.
- Mapping is NIC-style: a MAC port forwards to its paired DMA port, and a DMA port forwards to its paired MAC port.
- Packets with an illegal source port are dropped whole.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, master tdata width
C_S_AXIS_DATA_WIDTH, 256, slave tdata width
C_M_AXIS_TUSER_WIDTH, 128, master tuser width
C_S_AXIS_TUSER_WIDTH, 128, slave tuser width
SRC_PORT_POS, 16, LSB of the 8-bit one-hot source-port field in tuser
DST_PORT_POS, 24, LSB of the 8-bit one-hot destination-port field in tuser
FIFO_DEPTH_BITS, 2, log2 depth of the input fallthrough FIFO

Ports:
axis_aclk  in  1  clock
axis_resetn  in  1  asynchronous active-low reset
s_axis_tdata  in  256  slave data
s_axis_tkeep  in  32  slave byte enables
s_axis_tuser  in  128  slave metadata
s_axis_tvalid  in  1  slave valid
s_axis_tready  out  1  slave ready
s_axis_tlast  in  1  slave end of packet
m_axis_tdata  out  256  master data
m_axis_tkeep  out  32  master byte enables
m_axis_tuser  out  128  master metadata
m_axis_tvalid  out  1  master valid
m_axis_tready  in  1  master ready
m_axis_tlast  out  1  master end of packet
pkt_fwd_cnt  out  32  forwarded-packet counter (see Optional Feature)
pkt_drop_cnt  out  32  dropped-packet counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock axis_aclk; axis_resetn is asynchronous and active-low.
- Reset values: all m_axis_* outputs are 0. FIFO is empty. FSM is in HEADER. Both counters are 0.
- Reset mid-packet: the partial packet is discarded. After reset release, the next beat seen is treated as a header.
- Input side:
  - Beats enter a fallthrough FIFO of depth 2**FIFO_DEPTH_BITS.
  - The FIFO is written when s_axis_tvalid & s_axis_tready.
  - s_axis_tready = !fifo_nearly_full (one entry of slack).
- Output side:
  - m_axis_* are driven from a single output register.
  - The register loads when it is empty or m_axis_tready=1, and the FIFO is non-empty, and the FSM is not in DROP.
  - FIFO read enable is asserted on the same condition, or on any non-empty cycle while in DROP.
- Latency: a beat written at cycle N is visible on m_axis at cycle N+2 when m_axis_tready is held high. Full throughput is 1 beat per cycle.
- Flow control:
  - m_axis_tdata, m_axis_tkeep, m_axis_tuser and m_axis_tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid never drops without a handshake.
- FSM states: HEADER, PAYLOAD, DROP.
- HEADER, when the FIFO head is valid. Let src = head tuser[SRC_PORT_POS+7:SRC_PORT_POS] and dst = head tuser[DST_PORT_POS+7:DST_PORT_POS].
  - dst != 0: forward as-is. The software-preset destination is kept.
  - dst == 0 and src has exactly one bit set: write new_dst into the dst field.
    - If src has an even bit set (MAC): new_dst = src<<1.
    - If src has an odd bit set (DMA): new_dst = src>>1.
  - dst == 0 and src is 0 or not one-hot: go to DROP without emitting the beat.
  - After a forwarded header beat: stay in HEADER if tlast=1, otherwise go to PAYLOAD.
  - A dropped single-beat packet (tlast=1) stays in HEADER.
- PAYLOAD: beats pass through unmodified, including tuser. Return to HEADER on a handshaken tlast beat.
- DROP: beats are consumed at 1 per cycle with no output. Return to HEADER after the tlast beat is consumed.
- Counters: pkt_fwd_cnt increments on a handshaken output beat with tlast=1. pkt_drop_cnt increments when the FSM leaves DROP, or when a single-beat packet is dropped. Both wrap from 0xFFFFFFFF to 0.
- No other tuser bits, tdata or tkeep are modified.

Optional Feature:
- Macro: NIC_LOOKUP_STATS_EN.
- Defined: pkt_fwd_cnt and pkt_drop_cnt are implemented as described above.
- Undefined: both ports are tied to constant 0, and no counter flops are inferred. Forwarding and drop behaviour are identical in both builds.

Test Plan:
- 1-beat packet, src=0x01, dst=0, tready=1 → output at N+2 with dst=0x02; all other tuser bits and tdata unchanged; fwd cnt=1.
- 3-beat packet, src=0x08, dst=0 → header beat dst=0x04; beats 2-3 pass through bit-exact; tlast only on beat 3.
- Packet with src=0x02 and preset dst=0x10 → dst stays 0x10.
- src=0x03 (4 beats), followed by src=0x04 (1 beat) → first packet is absent from output; second arrives with dst=0x08; drop cnt=1, fwd cnt=1.
- m_axis_tready low for 10 cycles during continuous input → s_axis_tready falls once the FIFO is nearly full; no beat is lost or duplicated; output is held stable.
- axis_resetn asserted mid-PAYLOAD → outputs are 0 immediately; the following clean packet is forwarded correctly with counters restarted at 0.

Source files
------------

// File: rtl/nic_port_lookup.sv
// NIC-style output-port lookup: fills the destination-port byte of each packet header
// (MAC <-> paired DMA) and drops packets whose source port is not one-hot.
// Optional macro NIC_LOOKUP_STATS_EN enables the forwarded/dropped packet counters.
module nic_port_lookup #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       pkt_fwd_cnt,
  output logic [31:0]                       pkt_drop_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int FW    = 1 + KW + UW + DW;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE      = 1;
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE      = 1;
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_NEAR_FULL = DEPTH - 1;

  typedef enum logic [1:0] {
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;

  logic [FW-1:0]              r_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;

  logic                       w_wr;
  logic                       w_rd;
  logic                       w_load;
  logic                       w_empty;
  logic                       w_out_free;

  logic [FW-1:0]              w_head;
  logic                       w_head_last;
  logic [KW-1:0]              w_head_keep;
  logic [UW-1:0]              w_head_user;
  logic [DW-1:0]              w_head_data;

  logic [7:0]                 w_src;
  logic [7:0]                 w_dst;
  logic [7:0]                 w_new_dst;
  logic                       w_src_onehot;
  logic                       w_hdr_bad;
  logic [UW-1:0]              w_hdr_user;

  logic                       r_m_valid;
  logic                       r_m_last;
  logic [KW-1:0]              r_m_keep;
  logic [UW-1:0]              r_m_user;
  logic [DW-1:0]              r_m_data;

  // ---------------------------------------------------------------- input FIFO
  // One entry of slack: ready drops while there is still room for an in-flight beat.
  assign s_axis_tready = (r_count < CNT_NEAR_FULL);
  assign w_wr          = s_axis_tvalid && s_axis_tready;
  assign w_empty       = (r_count == '0);

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge axis_aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];
  assign {w_head_last, w_head_keep, w_head_user, w_head_data} = w_head;

  // ---------------------------------------------------------------- header lookup
  assign w_src        = w_head_user[SRC_PORT_POS +: 8];
  assign w_dst        = w_head_user[DST_PORT_POS +: 8];
  assign w_src_onehot = (w_src != 8'd0) && ((w_src & (w_src - 8'd1)) == 8'd0);
  // Even bit = MAC port, pairs with the DMA port one position up; odd bit pairs downward.
  assign w_new_dst    = (|(w_src & 8'h55)) ? (w_src << 1) : (w_src >> 1);
  assign w_hdr_bad    = (w_dst == 8'd0) && !w_src_onehot;

  always_comb begin
    w_hdr_user = w_head_user;
    if (w_dst == 8'd0 && w_src_onehot) begin
      w_hdr_user[DST_PORT_POS +: 8] = w_new_dst;
    end
  end

  // ---------------------------------------------------------------- FSM
  assign w_out_free = !r_m_valid || m_axis_tready;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) r_state <= S_HEADER;
    else              r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_rd         = 1'b0;
    unique case (r_state)
      S_HEADER: begin
        if (!w_empty) begin
          if (w_hdr_bad) begin
            // Illegal header is consumed without waiting for the output side.
            w_rd = 1'b1;
            if (!w_head_last) w_next_state = S_DROP;
          end else if (w_out_free) begin
            w_load = 1'b1;
            w_rd   = 1'b1;
            if (!w_head_last) w_next_state = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!w_empty && w_out_free) begin
          w_load = 1'b1;
          w_rd   = 1'b1;
          if (w_head_last) w_next_state = S_HEADER;
        end
      end
      S_DROP: begin
        if (!w_empty) begin
          w_rd = 1'b1;
          if (w_head_last) w_next_state = S_HEADER;
        end
      end
      default: w_next_state = S_HEADER;
    endcase
  end

  // ---------------------------------------------------------------- output register
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_keep  <= '0;
      r_m_user  <= '0;
      r_m_data  <= '0;
    end else if (w_out_free) begin
      r_m_valid <= w_load;
      if (w_load) begin
        r_m_last <= w_head_last;
        r_m_keep <= w_head_keep;
        r_m_user <= (r_state == S_HEADER) ? w_hdr_user : w_head_user;
        r_m_data <= w_head_data;
      end
    end
  end

  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tuser  = r_m_user;
  assign m_axis_tdata  = r_m_data;

  // ---------------------------------------------------------------- statistics
`ifdef NIC_LOOKUP_STATS_EN
  logic        w_fwd_done;
  logic        w_drop_done;
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_drop_cnt;

  assign w_fwd_done  = r_m_valid && m_axis_tready && r_m_last;
  assign w_drop_done = w_rd && w_head_last &&
                       ((r_state == S_DROP) || (r_state == S_HEADER && w_hdr_bad));

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_fwd_done)  r_fwd_cnt  <= r_fwd_cnt + 32'd1;
      if (w_drop_done) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign pkt_fwd_cnt  = r_fwd_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
`else
  assign pkt_fwd_cnt  = 32'd0;
  assign pkt_drop_cnt = 32'd0;
`endif

endmodule
